// File: rtl/tx_frame_arbiter.sv
// Round-robin, frame-granular arbiter onto the TX FIFO write port; 1-cycle grant latency,
// then one byte/cycle. FIFO_FULL stalls the granted frame; a silent requester is released by the watchdog.
module tx_frame_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255,
   parameter int CNT_W      = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]            REQ_LAST,
   output logic [NUM_REQ-1:0]            REQ_READY,
   input  logic                          FIFO_FULL,
   output logic [DATA_WIDTH-1:0]         TX_P_DATA,
   output logic                          TX_D_VLD,
   output logic [NUM_REQ-1:0]            GNT,
   output logic                          BUSY,
   output logic                          TIMEOUT_ERR
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t               state, state_nxt;
   logic [NUM_REQ-1:0]   gnt, gnt_nxt;
   logic [IDX_W-1:0]     gnt_idx, gnt_idx_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]     sel_idx, cand_idx, nxt_ptr;
   logic                 sel_found;
   logic [CNT_W-1:0]     stall_cnt, stall_cnt_nxt;
   logic                 terr, terr_nxt;
   logic                 busy, xfer, req_vld_g, req_last_g;

   assign busy       = (state == XFER);
   assign req_vld_g  = REQ_VALID[gnt_idx];
   assign req_last_g = REQ_LAST[gnt_idx];
   // RST gating keeps the reset cycle itself from writing a byte of the dropped frame
   assign xfer       = busy & RST & req_vld_g & ~FIFO_FULL;
   assign nxt_ptr    = IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!sel_found && REQ_VALID[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      gnt_nxt       = gnt;
      gnt_idx_nxt   = gnt_idx;
      rr_ptr_nxt    = rr_ptr;
      stall_cnt_nxt = stall_cnt;
      terr_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt     = XFER;
               gnt_nxt       = NUM_REQ'(1) << sel_idx;
               gnt_idx_nxt   = sel_idx;
               stall_cnt_nxt = '0;
            end
         end
         XFER: begin
            if (xfer) begin
               stall_cnt_nxt = '0;
               if (req_last_g) begin
                  state_nxt  = IDLE;
                  gnt_nxt    = '0;
                  rr_ptr_nxt = nxt_ptr;
               end
            end else if (!req_vld_g) begin
               // A full FIFO with valid data is not a stall; only a silent requester counts
               if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                  state_nxt     = IDLE;
                  gnt_nxt       = '0;
                  rr_ptr_nxt    = nxt_ptr;
                  stall_cnt_nxt = '0;
                  terr_nxt      = 1'b1;
               end else begin
                  stall_cnt_nxt = stall_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         gnt       <= '0;
         gnt_idx   <= '0;
         rr_ptr    <= '0;
         stall_cnt <= '0;
         terr      <= 1'b0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         gnt_idx   <= gnt_idx_nxt;
         rr_ptr    <= rr_ptr_nxt;
         stall_cnt <= stall_cnt_nxt;
         terr      <= terr_nxt;
      end
   end

   assign GNT         = gnt;
   assign BUSY        = busy;
   assign TIMEOUT_ERR = terr;
   assign TX_D_VLD    = xfer;
   assign REQ_READY   = gnt & {NUM_REQ{xfer}};
   assign TX_P_DATA   = busy ? REQ_DATA[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed vector bench for tx_frame_arbiter: table of per-cycle inputs and expected outputs,
// then hand sequences for backpressure, watchdog release and reset mid-frame.
module tb_tx_frame_arbiter;

   logic        CLK;
   logic        RST;
   logic [2:0]  REQ_VALID;
   logic [23:0] REQ_DATA;
   logic [2:0]  REQ_LAST;
   logic [2:0]  REQ_READY;
   logic        FIFO_FULL;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic [2:0]  GNT;
   logic        BUSY;
   logic        TIMEOUT_ERR;

   tx_frame_arbiter #(
      .NUM_REQ(3), .DATA_WIDTH(8), .TIMEOUT(8), .CNT_W(8)
   ) dut (
      .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
      .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .FIFO_FULL(FIFO_FULL),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .GNT(GNT), .BUSY(BUSY),
      .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        rst;
      logic [2:0]  vld;
      logic [2:0]  last;
      logic        full;
      logic [23:0] dat;
      logic [2:0]  e_gnt;
      logic        e_txv;
      logic [7:0]  e_pd;
      logic [2:0]  e_rdy;
      logic        e_busy;
      logic        e_terr;
   } vec_t;

   int tests    = 0;
   int fails    = 0;
   int wr_count = 0;
   int base;

   // Ready mirrors the grant on a write cycle; BUSY is simply "a grant is held"
   function automatic vec_t mk(input logic rst, input logic [2:0] vld, input logic [2:0] last,
                               input logic full, input logic [23:0] dat, input logic [2:0] gnt,
                               input logic txv, input logic [7:0] pd, input logic terr);
      vec_t v;
      v.rst = rst; v.vld = vld; v.last = last; v.full = full; v.dat = dat;
      v.e_gnt = gnt; v.e_txv = txv; v.e_pd = pd; v.e_terr = terr;
      v.e_rdy = txv ? gnt : 3'b000;
      v.e_busy = (gnt != 3'b000);
      return v;
   endfunction

   task automatic chk(input string tag, input int idx, input string what,
                      input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, what, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag, input int idx);
      RST       = v.rst;
      REQ_VALID = v.vld;
      REQ_LAST  = v.last;
      FIFO_FULL = v.full;
      REQ_DATA  = v.dat;
      @(negedge CLK);
      if (TX_D_VLD) wr_count++;
      chk(tag, idx, "gnt",   32'(GNT),         32'(v.e_gnt));
      chk(tag, idx, "txvld", 32'(TX_D_VLD),    32'(v.e_txv));
      chk(tag, idx, "pdata", 32'(TX_P_DATA),   32'(v.e_pd));
      chk(tag, idx, "ready", 32'(REQ_READY),   32'(v.e_rdy));
      chk(tag, idx, "busy",  32'(BUSY),        32'(v.e_busy));
      chk(tag, idx, "terr",  32'(TIMEOUT_ERR), 32'(v.e_terr));
      @(posedge CLK);
      #1;
   endtask

   vec_t tbl [22];

   initial begin
      RST = 1'b0; REQ_VALID = '0; REQ_LAST = '0; FIFO_FULL = 1'b0; REQ_DATA = '0;
      @(posedge CLK);
      #1;

      // reset held with every requester asking
      tbl[0]  = mk(0, 3'b111, 3'b111, 0, 24'h0, 3'b000, 0, 8'h00, 0);
      tbl[1]  = mk(0, 3'b111, 3'b111, 0, 24'h0, 3'b000, 0, 8'h00, 0);
      tbl[2]  = mk(0, 3'b111, 3'b111, 0, 24'h0, 3'b000, 0, 8'h00, 0);
      // req1 three-byte frame
      tbl[3]  = mk(1, 3'b010, 3'b000, 0, {8'h00, 8'hA1, 8'h00}, 3'b000, 0, 8'h00, 0);
      tbl[4]  = mk(1, 3'b010, 3'b000, 0, {8'h00, 8'hA1, 8'h00}, 3'b010, 1, 8'hA1, 0);
      tbl[5]  = mk(1, 3'b010, 3'b000, 0, {8'h00, 8'hA2, 8'h00}, 3'b010, 1, 8'hA2, 0);
      tbl[6]  = mk(1, 3'b010, 3'b010, 0, {8'h00, 8'hA3, 8'h00}, 3'b010, 1, 8'hA3, 0);
      tbl[7]  = mk(1, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0);
      // reset pointer, then all three stream 2-byte frames: order 0,1,2,0
      tbl[8]  = mk(0, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0);
      tbl[9]  = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b000, 0, 8'h00, 0);
      tbl[10] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b001, 1, 8'h10, 0);
      tbl[11] = mk(1, 3'b111, 3'b001, 0, {8'h30, 8'h20, 8'h11}, 3'b001, 1, 8'h11, 0);
      tbl[12] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b000, 0, 8'h00, 0);
      tbl[13] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b010, 1, 8'h20, 0);
      tbl[14] = mk(1, 3'b111, 3'b010, 0, {8'h30, 8'h21, 8'h10}, 3'b010, 1, 8'h21, 0);
      tbl[15] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b000, 0, 8'h00, 0);
      tbl[16] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b100, 1, 8'h30, 0);
      tbl[17] = mk(1, 3'b111, 3'b100, 0, {8'h31, 8'h20, 8'h10}, 3'b100, 1, 8'h31, 0);
      tbl[18] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b000, 0, 8'h00, 0);
      tbl[19] = mk(1, 3'b111, 3'b000, 0, {8'h30, 8'h20, 8'h10}, 3'b001, 1, 8'h10, 0);
      tbl[20] = mk(1, 3'b001, 3'b001, 0, {8'h30, 8'h20, 8'h11}, 3'b001, 1, 8'h11, 0);
      tbl[21] = mk(1, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0);

      for (int i = 0; i < 22; i++) apply(tbl[i], "tbl", i);

      // backpressure: 10 full cycles mid-frame (longer than the watchdog), then full on LAST
      apply(mk(1, 3'b010, 3'b000, 0, {8'h00, 8'hB1, 8'h00}, 3'b000, 0, 8'h00, 0), "bp", 0);
      apply(mk(1, 3'b010, 3'b000, 0, {8'h00, 8'hB1, 8'h00}, 3'b010, 1, 8'hB1, 0), "bp", 1);
      for (int i = 0; i < 10; i++)
         apply(mk(1, 3'b010, 3'b000, 1, {8'h00, 8'hB2, 8'h00}, 3'b010, 0, 8'hB2, 0), "bp_full", i);
      apply(mk(1, 3'b010, 3'b000, 0, {8'h00, 8'hB2, 8'h00}, 3'b010, 1, 8'hB2, 0), "bp", 2);
      for (int i = 0; i < 2; i++)
         apply(mk(1, 3'b010, 3'b010, 1, {8'h00, 8'hB3, 8'h00}, 3'b010, 0, 8'hB3, 0), "bp_lastfull", i);
      apply(mk(1, 3'b010, 3'b010, 0, {8'h00, 8'hB3, 8'h00}, 3'b010, 1, 8'hB3, 0), "bp", 3);
      apply(mk(1, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0), "bp", 4);

      // watchdog: req0 goes silent after one byte while req2 waits
      apply(mk(0, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0), "wd_rst", 0);
      apply(mk(1, 3'b001, 3'b000, 0, {8'h00, 8'h00, 8'hC0}, 3'b000, 0, 8'h00, 0), "wd", 0);
      apply(mk(1, 3'b101, 3'b000, 0, {8'hE0, 8'h00, 8'hC0}, 3'b001, 1, 8'hC0, 0), "wd", 1);
      for (int i = 0; i < 8; i++)
         apply(mk(1, 3'b100, 3'b000, 0, {8'hE0, 8'h00, 8'h00}, 3'b001, 0, 8'h00, 0), "wd_stall", i);
      apply(mk(1, 3'b100, 3'b100, 0, {8'hE0, 8'h00, 8'h00}, 3'b000, 0, 8'h00, 1), "wd", 2);
      apply(mk(1, 3'b100, 3'b100, 0, {8'hE0, 8'h00, 8'h00}, 3'b100, 1, 8'hE0, 0), "wd", 3);
      apply(mk(1, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0), "wd", 4);

      // reset after the first of three bytes: exactly one write
      base = wr_count;
      apply(mk(1, 3'b001, 3'b000, 0, {8'h00, 8'h00, 8'hF1}, 3'b000, 0, 8'h00, 0), "mid", 0);
      apply(mk(1, 3'b001, 3'b000, 0, {8'h00, 8'h00, 8'hF1}, 3'b001, 1, 8'hF1, 0), "mid", 1);
      apply(mk(0, 3'b001, 3'b000, 0, {8'h00, 8'h00, 8'hF2}, 3'b001, 0, 8'hF2, 0), "mid", 2);
      apply(mk(1, 3'b000, 3'b000, 0, 24'h0, 3'b000, 0, 8'h00, 0), "mid", 3);
      chk("mid_writes", 0, "count", 32'(wr_count - base), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
